// File: rtl/ok2wbm_pkg.sv
// Shared definitions for the Opal Kelly pipe to Wishbone burst bridge.
//   - Wishbone cycle-type (CTI) and burst-type (BTE) encodings
//   - Bridge FSM state type
package ok2wbm_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_CONST   = 3'b001;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    StIdle,
    StWaitWd,
    StActive
  } state_e;

endpackage

// File: rtl/ok2wbm_wr_fifo.sv
// Synchronous first-word-fall-through write-data FIFO.
//   clk_i, rst_i   : clock, synchronous active-high reset (empties the FIFO)
//   flush_i        : discard all contents; has priority over push/pop
//   push_i/data_i  : write request and data; dropped when full unless popping
//   pop_i          : remove head entry (ignored when empty)
//   data_o         : head entry, valid whenever empty_o is low
//   count_o        : number of stored entries
//   full_o/empty_o : occupancy flags
module ok2wbm_wr_fifo #(
  parameter int unsigned DW         = 16,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            flush_i,
  input  logic                            push_i,
  input  logic [DW-1:0]                   data_i,
  input  logic                            pop_i,
  output logic [DW-1:0]                   data_o,
  output logic [$clog2(FIFO_DEPTH):0]     count_o,
  output logic                            full_o,
  output logic                            empty_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push then.
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_i);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/ok2wbm_burst.sv
// Opal Kelly trigger/pipe to Wishbone B4 registered-feedback burst master.
//   cmd_*      : one-cycle command trigger with direction, address mode, start address, length
//   wr_*       : write-data pipe into the buffered write FIFO (wr_ready_o = not full)
//   rd_*       : read beat data with one-cycle strobe per acked beat
//   busy_o, done_o, err_o, timeout_o : transaction status
//   irq_o      : wb_int_i delayed one cycle
//   wb_*       : Wishbone master port (word addressed, linear bursts)
module ok2wbm_burst
  import ok2wbm_pkg::*;
#(
  parameter int unsigned DW         = 16,
  parameter int unsigned AW         = 16,
  parameter int unsigned LW         = 10,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TO_CYCLES  = 1024
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            cmd_valid_i,
  input  logic            cmd_write_i,
  input  logic            cmd_incr_i,
  input  logic [AW-1:0]   cmd_addr_i,
  input  logic [LW-1:0]   cmd_len_i,
  input  logic [DW-1:0]   wr_data_i,
  input  logic            wr_valid_i,
  output logic            wr_ready_o,
  output logic [DW-1:0]   rd_data_o,
  output logic            rd_valid_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            err_o,
  output logic            timeout_o,
  output logic            irq_o,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_adr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic [2:0]      wb_cti_o,
  output logic [1:0]      wb_bte_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i,
  input  logic            wb_err_i,
  input  logic            wb_int_i
);

  localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned ToW = (TO_CYCLES > 1) ? $clog2(TO_CYCLES) : 1;
  localparam logic [ToW-1:0] ToLast = ToW'((TO_CYCLES == 0) ? 0 : TO_CYCLES - 1);

  state_e          state_q, state_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [LW-1:0]   rem_q, rem_d;
  logic            burst_q, burst_d;
  logic            we_q, we_d;
  logic            incr_q, incr_d;
  logic            cyc_q, cyc_d;
  logic            stb_q, stb_d;
  logic [ToW-1:0]  to_cnt_q, to_cnt_d;
  logic            timeout_q, timeout_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            rd_valid_q, rd_valid_d;
  logic [DW-1:0]   rd_data_q, rd_data_d;
  logic            irq_q;

  logic            fifo_pop, fifo_flush, fifo_full, fifo_empty;
  logic [DW-1:0]   fifo_head;
  logic [CW-1:0]   fifo_count;
  logic            to_hit;

  ok2wbm_wr_fifo #(
    .DW         (DW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_wr_fifo (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .flush_i (fifo_flush),
    .push_i  (wr_valid_i),
    .data_i  (wr_data_i),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Last permitted stall cycle with no termination from the slave.
  assign to_hit = (TO_CYCLES != 0) && (state_q == StActive) && (to_cnt_q == ToLast) &&
                  !wb_ack_i && !wb_err_i;

  always_comb begin
    state_d    = state_q;
    adr_d      = adr_q;
    rem_d      = rem_q;
    burst_d    = burst_q;
    we_d       = we_q;
    incr_d     = incr_q;
    cyc_d      = cyc_q;
    stb_d      = stb_q;
    to_cnt_d   = '0;
    timeout_d  = timeout_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    rd_valid_d = 1'b0;
    rd_data_d  = rd_data_q;
    fifo_pop   = 1'b0;
    fifo_flush = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          adr_d     = cmd_addr_i;
          rem_d     = (cmd_len_i == '0) ? LW'(1) : cmd_len_i;
          burst_d   = (cmd_len_i > LW'(1));
          we_d      = cmd_write_i;
          incr_d    = cmd_incr_i;
          timeout_d = 1'b0;
          cyc_d     = 1'b1;
          if (cmd_write_i && fifo_empty) begin
            state_d = StWaitWd;
            stb_d   = 1'b0;
          end else begin
            state_d = StActive;
            stb_d   = 1'b1;
          end
        end
      end

      StWaitWd: begin
        if (!fifo_empty) begin
          state_d = StActive;
          stb_d   = 1'b1;
        end
      end

      StActive: begin
        if (wb_err_i || to_hit) begin
          // Error beats an ack in the same cycle; leftover write data is discarded.
          state_d    = StIdle;
          cyc_d      = 1'b0;
          stb_d      = 1'b0;
          we_d       = 1'b0;
          err_d      = 1'b1;
          fifo_flush = 1'b1;
          timeout_d  = timeout_q | to_hit;
        end else if (wb_ack_i) begin
          rem_d = rem_q - LW'(1);
          if (incr_q) adr_d = adr_q + AW'(1);
          if (we_q) begin
            fifo_pop = 1'b1;
          end else begin
            rd_valid_d = 1'b1;
            rd_data_d  = wb_dat_i;
          end
          if (rem_q == LW'(1)) begin
            state_d = StIdle;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
            done_d  = 1'b1;
          end else if (we_q && (fifo_count == CW'(1)) && !wr_valid_i) begin
            // Popping the last word with nothing arriving: park with stb low.
            state_d = StWaitWd;
            stb_d   = 1'b0;
          end
        end else begin
          to_cnt_d = to_cnt_q + ToW'(1);
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= StIdle;
      adr_q      <= '0;
      rem_q      <= '0;
      burst_q    <= 1'b0;
      we_q       <= 1'b0;
      incr_q     <= 1'b0;
      cyc_q      <= 1'b0;
      stb_q      <= 1'b0;
      to_cnt_q   <= '0;
      timeout_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      adr_q      <= adr_d;
      rem_q      <= rem_d;
      burst_q    <= burst_d;
      we_q       <= we_d;
      incr_q     <= incr_d;
      cyc_q      <= cyc_d;
      stb_q      <= stb_d;
      to_cnt_q   <= to_cnt_d;
      timeout_q  <= timeout_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      irq_q      <= wb_int_i;
    end
  end

  always_comb begin
    wb_cti_o = CTI_CLASSIC;
    if (cyc_q && burst_q) begin
      if (rem_q == LW'(1)) wb_cti_o = CTI_EOB;
      else if (incr_q)     wb_cti_o = CTI_INCR;
      else                 wb_cti_o = CTI_CONST;
    end
  end

  assign wr_ready_o = ~fifo_full;
  assign rd_data_o  = rd_data_q;
  assign rd_valid_o = rd_valid_q;
  assign busy_o     = cyc_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign timeout_o  = timeout_q;
  assign irq_o      = irq_q;
  assign wb_cyc_o   = cyc_q;
  assign wb_stb_o   = stb_q;
  assign wb_we_o    = we_q;
  assign wb_adr_o   = adr_q;
  // Empty FIFO storage is uninitialised; present zeros instead.
  assign wb_dat_o   = fifo_empty ? '0 : fifo_head;
  assign wb_sel_o   = {(DW/8){cyc_q}};
  assign wb_bte_o   = BTE_LINEAR;

endmodule

// File: tb/tb_ok2wbm_burst.sv
module tb_ok2wbm_burst;

  typedef struct {
    logic [15:0] adr;
    logic [15:0] dat;
    logic [2:0]  cti;
    logic        we;
  } beat_t;

  logic        clk = 1'b0;
  logic        wb_rst_i;
  logic        cmd_valid_i, cmd_write_i, cmd_incr_i;
  logic [15:0] cmd_addr_i;
  logic [9:0]  cmd_len_i;
  logic [15:0] wr_data_i;
  logic        wr_valid_i, wr_ready_o;
  logic [15:0] rd_data_o;
  logic        rd_valid_o, busy_o, done_o, err_o, timeout_o, irq_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [15:0] wb_adr_o, wb_dat_o, wb_dat_i;
  logic [1:0]  wb_sel_o, wb_bte_o;
  logic [2:0]  wb_cti_o;
  logic        wb_ack_i, wb_err_i, wb_int_i;
  logic [63:0] outvec;

  // Written only by the initial block.
  int          nchk = 0, nfail = 0;
  int          slv_ws = 0, slv_errb = 0;
  bit          slv_hang = 0, slv_ovr_en = 0, push_force = 0;
  logic [15:0] slv_ovr = '0, seed = '0;
  int          clr_gen = 0, push_wr = 0;
  logic [15:0] push_buf [256];
  logic [15:0] exp_words [$];

  // Written only by the negedge monitor/slave/pusher block.
  int          clr_seen = 0, push_rd = 0, cyc_n = 0;
  beat_t       beat_q [$];
  logic [15:0] rd_q [$];
  logic [15:0] mem [logic [15:0]];
  int          n_done = 0, n_err = 0, stb_lo_cyc = 0, stb_hi = 0, busy_bad = 0;
  int          ack_at = 0, done_at = 0, slv_beat = 0, ws_cnt = 0;
  logic        done_cyc = 1'b0;

  always #5 clk = ~clk;

  ok2wbm_burst #(
    .DW(16), .AW(16), .LW(10), .FIFO_DEPTH(4), .TO_CYCLES(16)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (wb_rst_i),
    .cmd_valid_i(cmd_valid_i),
    .cmd_write_i(cmd_write_i),
    .cmd_incr_i (cmd_incr_i),
    .cmd_addr_i (cmd_addr_i),
    .cmd_len_i  (cmd_len_i),
    .wr_data_i  (wr_data_i),
    .wr_valid_i (wr_valid_i),
    .wr_ready_o (wr_ready_o),
    .rd_data_o  (rd_data_o),
    .rd_valid_o (rd_valid_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .timeout_o  (timeout_o),
    .irq_o      (irq_o),
    .wb_cyc_o   (wb_cyc_o),
    .wb_stb_o   (wb_stb_o),
    .wb_we_o    (wb_we_o),
    .wb_adr_o   (wb_adr_o),
    .wb_dat_o   (wb_dat_o),
    .wb_sel_o   (wb_sel_o),
    .wb_cti_o   (wb_cti_o),
    .wb_bte_o   (wb_bte_o),
    .wb_dat_i   (wb_dat_i),
    .wb_ack_i   (wb_ack_i),
    .wb_err_i   (wb_err_i),
    .wb_int_i   (wb_int_i)
  );

  assign outvec = {wr_ready_o, rd_data_o, rd_valid_o, done_o, err_o, timeout_o, irq_o,
                   wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_cti_o,
                   wb_bte_o};

  function automatic logic [15:0] slave_word(input logic [15:0] a);
    if (slv_ovr_en) return slv_ovr;
    if (mem.exists(a)) return mem[a];
    return 16'(a * 16'h9E37) ^ seed;
  endfunction

  // Monitor, Wishbone slave and write-pipe pusher, all sampling away from posedge.
  always @(negedge clk) begin
    beat_t b;
    logic  ack, err;
    cyc_n++;
    if (clr_seen != clr_gen) begin
      clr_seen = clr_gen;
      beat_q.delete();
      rd_q.delete();
      n_done = 0; n_err = 0; stb_lo_cyc = 0; stb_hi = 0;
      ack_at = 0; done_at = 0; slv_beat = 0; ws_cnt = 0; done_cyc = 1'b0;
    end
    if (wb_cyc_o && !wb_stb_o) stb_lo_cyc++;
    if (wb_stb_o) stb_hi++;
    if (busy_o !== wb_cyc_o) busy_bad++;
    if (rd_valid_o) rd_q.push_back(rd_data_o);
    if (done_o) begin n_done++; done_at = cyc_n; done_cyc = wb_cyc_o; end
    if (err_o) n_err++;

    ack = 1'b0; err = 1'b0;
    if (wb_cyc_o && wb_stb_o && !slv_hang) begin
      if (ws_cnt < slv_ws) begin
        ws_cnt++;
      end else begin
        ws_cnt = 0;
        slv_beat++;
        b.adr = wb_adr_o; b.cti = wb_cti_o; b.we = wb_we_o;
        if (wb_we_o) begin
          b.dat = wb_dat_o;
          mem[wb_adr_o] = wb_dat_o;
        end else begin
          b.dat = slave_word(wb_adr_o);
        end
        wb_dat_i = b.dat;
        beat_q.push_back(b);
        ack = 1'b1;
        if (slv_beat == slv_errb) err = 1'b1;
        ack_at = cyc_n;
      end
    end else begin
      ws_cnt = 0;
    end
    wb_ack_i = ack;
    wb_err_i = err;

    if (push_rd < push_wr && (wr_ready_o || push_force)) begin
      wr_valid_i = 1'b1;
      wr_data_i  = push_buf[push_rd];
      push_rd++;
    end else begin
      wr_valid_i = 1'b0;
      wr_data_i  = '0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic enqueue(input logic [15:0] w);
    push_buf[push_wr] = w;
    push_wr++;
  endtask

  task automatic drain_pusher();
    int cnt = 0;
    while (push_rd < push_wr && cnt < 200) begin @(negedge clk); cnt++; end
    chk("pusher_drain", 64'(cnt < 200), 64'd1);
    @(negedge clk);
  endtask

  task automatic run_cmd(input bit wr, input bit inc, input logic [15:0] addr,
                         input logic [9:0] len, input int ws, input int errb,
                         input bit hang, input bit poke);
    int cnt = 0;
    slv_ws = ws; slv_errb = errb; slv_hang = hang;
    clr_gen++;
    @(negedge clk);
    cmd_write_i = wr; cmd_incr_i = inc; cmd_addr_i = addr; cmd_len_i = len;
    cmd_valid_i = 1'b1;
    @(negedge clk);
    if (poke) begin
      // A second trigger while busy must be ignored.
      cmd_write_i = ~wr; cmd_addr_i = ~addr;
      @(negedge clk);
    end
    cmd_valid_i = 1'b0;
    while (wb_cyc_o && cnt < 2000) begin @(negedge clk); cnt++; end
    chk("txn_terminates", 64'(cnt < 2000), 64'd1);
    repeat (2) @(negedge clk);
  endtask

  // Reference: beat sequence derived from length, address mode and error beat.
  task automatic check_burst(input string tag, input bit wr, input bit inc,
                             input logic [15:0] addr, input int len, input int errb);
    int          n, nb, nrd;
    bit          erred;
    logic [15:0] a;
    logic [2:0]  cti;
    n     = (len == 0) ? 1 : len;
    erred = (errb >= 1 && errb <= n);
    nb    = erred ? errb : n;
    nrd   = wr ? 0 : (erred ? errb - 1 : n);
    chk({tag, "_nbeats"}, 64'(beat_q.size()), 64'(nb));
    chk({tag, "_nrdvalid"}, 64'(rd_q.size()), 64'(nrd));
    for (int i = 0; i < nb && i < beat_q.size(); i++) begin
      a   = addr + (inc ? 16'(i) : 16'd0);
      cti = (n == 1) ? 3'b000 : (i == n - 1) ? 3'b111 : (inc ? 3'b010 : 3'b001);
      chk($sformatf("%s_adr%0d", tag, i), 64'(beat_q[i].adr), 64'(a));
      chk($sformatf("%s_cti%0d", tag, i), 64'(beat_q[i].cti), 64'(cti));
      chk($sformatf("%s_we%0d", tag, i), 64'(beat_q[i].we), 64'(wr));
      if (wr && i < exp_words.size())
        chk($sformatf("%s_wdat%0d", tag, i), 64'(beat_q[i].dat), 64'(exp_words[i]));
      if (!wr && i < nrd && i < rd_q.size())
        chk($sformatf("%s_rdat%0d", tag, i), 64'(rd_q[i]), 64'(slave_word(a)));
    end
    chk({tag, "_done"}, 64'(n_done), erred ? 64'd0 : 64'd1);
    chk({tag, "_err"}, 64'(n_err), erred ? 64'd1 : 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a;
    int          len;
    bit          wr, inc;
    seed = 16'($urandom);
    wb_rst_i = 1'b1; wb_int_i = 1'b0;
    cmd_valid_i = 1'b0; cmd_write_i = 1'b0; cmd_incr_i = 1'b0;
    cmd_addr_i = '0; cmd_len_i = '0;
    repeat (3) @(negedge clk);
    wb_rst_i = 1'b0;
    @(negedge clk);
    chk("reset_outputs", outvec, {1'b1, 63'd0});

    // Interrupt passthrough, one cycle of latency.
    wb_int_i = 1'b1;
    @(negedge clk);
    chk("irq_high", 64'(irq_o), 64'd1);
    wb_int_i = 1'b0;
    @(negedge clk);
    chk("irq_low", 64'(irq_o), 64'd0);

    // Single read, 2 wait states, slave returns 0xBEEF; a busy re-trigger is ignored.
    slv_ovr_en = 1'b1; slv_ovr = 16'hBEEF;
    run_cmd(1'b0, 1'b1, 16'h0012, 10'd1, 2, 0, 1'b0, 1'b1);
    check_burst("rd1", 1'b0, 1'b1, 16'h0012, 1, 0);
    chk("rd1_data", 64'(rd_q.size() > 0 ? rd_q[0] : 16'h0), 64'hBEEF);
    chk("rd1_done_lat", 64'(done_at - ack_at), 64'd1);
    chk("rd1_cyc_at_done", 64'(done_cyc), 64'd0);
    slv_ovr_en = 1'b0;

    // Overfill a 4-deep FIFO: fifth push is dropped.
    push_force = 1'b1;
    for (int i = 0; i < 5; i++) enqueue(16'h00A0 + 16'(i));
    drain_pusher();
    push_force = 1'b0;
    chk("fifo_full_ready", 64'(wr_ready_o), 64'd0);
    exp_words = '{16'h00A0, 16'h00A1, 16'h00A2, 16'h00A3};
    run_cmd(1'b1, 1'b1, 16'h0100, 10'd4, 0, 0, 1'b0, 1'b0);
    check_burst("wrinc", 1'b1, 1'b1, 16'h0100, 4, 0);
    chk("wrinc_ready_after", 64'(wr_ready_o), 64'd1);

    // Single write with empty FIFO: holds in wait until data arrives (dropped word absent).
    exp_words = '{16'h0055};
    fork
      run_cmd(1'b1, 1'b0, 16'h0300, 10'd0, 0, 0, 1'b0, 1'b0);
      begin repeat (4) @(negedge clk); enqueue(16'h0055); end
    join
    check_burst("wrwait", 1'b1, 1'b0, 16'h0300, 0, 0);
    chk("wrwait_stb_low", 64'(stb_lo_cyc >= 3), 64'd1);

    // Underrun mid-burst: 1 word preloaded, rest 5 cycles after the trigger.
    enqueue(16'h1111);
    drain_pusher();
    exp_words = '{16'h1111, 16'h2222, 16'h3333};
    fork
      run_cmd(1'b1, 1'b1, 16'h0400, 10'd3, 0, 0, 1'b0, 1'b0);
      begin repeat (6) @(negedge clk); enqueue(16'h2222); enqueue(16'h3333); end
    join
    check_burst("underrun", 1'b1, 1'b1, 16'h0400, 3, 0);
    chk("underrun_stb_low", 64'(stb_lo_cyc > 0), 64'd1);
    chk("underrun_no_timeout", 64'(timeout_o), 64'd0);

    // Constant-address read burst, err together with ack on beat 3.
    run_cmd(1'b0, 1'b0, 16'h0777, 10'd8, 1, 3, 1'b0, 1'b0);
    check_burst("rderr", 1'b0, 1'b0, 16'h0777, 8, 3);

    // Timeout: slave never answers.
    run_cmd(1'b0, 1'b1, 16'h0500, 10'd2, 0, 0, 1'b1, 1'b0);
    chk("to_stb_cycles", 64'(stb_hi), 64'd16);
    chk("to_err", 64'(n_err), 64'd1);
    chk("to_done", 64'(n_done), 64'd0);
    chk("to_sticky", 64'(timeout_o), 64'd1);
    run_cmd(1'b0, 1'b0, 16'h0200, 10'd1, 0, 0, 1'b0, 1'b0);
    chk("to_cleared", 64'(timeout_o), 64'd0);

    // Address wrap.
    run_cmd(1'b0, 1'b1, 16'hFFFE, 10'd4, 1, 0, 1'b0, 1'b0);
    check_burst("wrap", 1'b0, 1'b1, 16'hFFFE, 4, 0);

    // Reset in the middle of a read burst.
    slv_ws = 1; slv_errb = 0; slv_hang = 1'b0;
    clr_gen++;
    @(negedge clk);
    cmd_write_i = 1'b0; cmd_incr_i = 1'b1; cmd_addr_i = 16'h0040; cmd_len_i = 10'd8;
    cmd_valid_i = 1'b1;
    @(negedge clk);
    cmd_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mid_busy_before", 64'(busy_o), 64'd1);
    wb_rst_i = 1'b1;
    @(negedge clk);
    chk("rst_mid_outputs", outvec, {1'b1, 63'd0});
    @(negedge clk);
    wb_rst_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid_no_done", 64'(n_done), 64'd0);
    chk("rst_mid_no_err", 64'(n_err), 64'd0);

    // Randomised transactions against the reference sequence.
    for (int t = 0; t < 10; t++) begin
      wr  = 1'($urandom_range(0, 1));
      inc = 1'($urandom_range(0, 1));
      a   = (t % 3 == 0) ? 16'hFFFC + 16'($urandom_range(0, 3)) : 16'($urandom);
      len = $urandom_range(0, 6);
      exp_words.delete();
      if (wr) begin
        for (int i = 0; i < ((len == 0) ? 1 : len); i++) begin
          exp_words.push_back(16'($urandom));
          enqueue(exp_words[i]);
        end
      end
      run_cmd(wr, inc, a, 10'(len), $urandom_range(0, 2), 0, 1'b0, 1'b0);
      check_burst($sformatf("rnd%0d", t), wr, inc, a, len, 0);
    end

    chk("busy_tracks_cyc", 64'(busy_bad), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
